// File: rtl/uart_tx_buffered_pkg.sv
// ============================================================================
//  Package  : uart_pkg
//  Purpose  : Shared state encoding, width helpers and defaults for uart_tx_buffered.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int c_DEFAULT_BAUD_DIV = 868;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a completely full FIFO is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_buffered_if.sv
// ============================================================================
//  Interface : uart_tx_buffered_if
//  Purpose   : LSU-side push port and status/serial outputs of the buffered UART TX.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_buffered_if
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);

  localparam int c_CNT_W = count_width(FIFO_DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [c_CNT_W-1:0] count;
  logic              overflow;
  logic              busy;
  logic              tx;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow, busy, tx
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow, busy, tx
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Flat-register synchronous FIFO with registered full/empty flags and a
//             sticky overflow flag for dropped pushes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int PTR_W     = ptr_width(FIFO_DEPTH),
  localparam int CNT_W     = count_width(FIFO_DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_wr_en,
  input  wire logic [DATA_W-1:0] i_wr_data,
  input  wire logic              i_rd_en,
  output logic      [DATA_W-1:0] o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic      [CNT_W-1:0]  o_count,
  output logic                   o_overflow
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_nxt;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (i_wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// ============================================================================
//  Module   : uart_tx_buffered
//  Purpose  : FIFO-buffered UART transmitter (start, DATA_W bits LSB first, optional
//             even parity, STOP_BITS stop bits). Optional feature macro: UART_TX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = c_DEFAULT_BAUD_DIV,
  parameter int STOP_BITS  = 1
) (
  input wire logic         clk,
  input wire logic         reset,
  uart_tx_buffered_if.slave bus
);

  localparam int c_BAUD_W = $clog2(BAUD_DIV);
  localparam int c_IDX_W  = 4;

  localparam logic [2:0] c_ST_IDLE   = IDLE;
  localparam logic [2:0] c_ST_START  = START;
  localparam logic [2:0] c_ST_DATA   = DATA;
  localparam logic [2:0] c_ST_STOP   = STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_ST_PARITY = PARITY;
`endif

  logic [2:0]          r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [c_IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_tx;
`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif

  logic                w_empty;
  logic                w_fifo_rd;
  logic [DATA_W-1:0]   w_fifo_data;
  logic                w_bit_end;
  logic                w_tx_nxt;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (bus.wr_en),
    .i_wr_data  (bus.wr_data),
    .i_rd_en    (w_fifo_rd),
    .o_rd_data  (w_fifo_data),
    .o_full     (bus.full),
    .o_empty    (w_empty),
    .o_count    (bus.count),
    .o_overflow (bus.overflow)
  );

  assign w_fifo_rd = (r_state == c_ST_IDLE) && !w_empty;
  assign w_bit_end = (r_baud == c_BAUD_W'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= c_ST_IDLE;
      r_baud   <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_baud <= r_baud + 1'b1;
      case (r_state)
        c_ST_IDLE: begin
          r_baud <= '0;
          r_idx  <= '0;
          if (w_fifo_rd) begin
            r_shift <= w_fifo_data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_fifo_data;
`endif
            r_state <= c_ST_START;
          end
        end
        c_ST_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_state <= c_ST_DATA;
          end
        end
        c_ST_DATA: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_idx == c_IDX_W'(DATA_W - 1)) begin
              r_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= c_ST_PARITY;
`else
              r_state <= c_ST_STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        c_ST_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= c_ST_STOP;
          end
        end
`endif
        c_ST_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_idx == c_IDX_W'(STOP_BITS - 1)) begin
              r_idx   <= '0;
              r_state <= c_ST_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_baud  <= '0;
          r_state <= c_ST_IDLE;
        end
      endcase
      // Line is registered, so it trails the state by one clock.
      r_tx <= w_tx_nxt;
    end
  end

  always_comb begin
    w_tx_nxt = 1'b1;
    case (r_state)
      c_ST_START:  w_tx_nxt = 1'b0;
      c_ST_DATA:   w_tx_nxt = r_shift[0];
`ifdef UART_TX_PARITY_EN
      c_ST_PARITY: w_tx_nxt = r_parity;
`endif
      default:     w_tx_nxt = 1'b1;
    endcase
  end

  assign bus.empty = w_empty;
  assign bus.busy  = (r_state != c_ST_IDLE);
  assign bus.tx    = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
//  Module   : tb_uart_tx_buffered
//  Purpose  : Randomised scoreboard bench with a timing-level reference model and
//             a serial-line decoder for uart_tx_buffered.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buffered;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BD    = 4;
  localparam int SB    = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR   = 1;
`else
  localparam int PAR   = 0;
`endif
  localparam int FRAME_BITS = 1 + DW + PAR + SB;
  localparam int FB         = FRAME_BITS * BD;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uart_tx_buffered_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_buffered #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .BAUD_DIV   (BD),
    .STOP_BITS  (SB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accepted byte with the edge it is sampled on and the
  // edge it leaves the FIFO; the line falls one edge after the pop.
  typedef struct {
    logic [DW-1:0] data;
    int            push_e;
    int            pop_e;
  } ent_t;
  typedef struct {
    logic [DW-1:0] data;
    int            start;
  } exp_t;

  ent_t hist[$];
  exp_t sb[$];
  int   last_pop    = -1000000;
  int   ovf_e       = 1 << 30;
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic model_push(input logic [DW-1:0] d);
    int e;
    int occ;
    int p;
    e   = cyc + 1;
    occ = 0;
    foreach (hist[i]) begin
      if (hist[i].push_e < e && hist[i].pop_e >= e) occ++;
    end
    if (occ >= DEPTH) begin
      if (ovf_e > e) ovf_e = e;
    end else begin
      p = (e + 1 > last_pop + FB + 1) ? e + 1 : last_pop + FB + 1;
      last_pop = p;
      hist.push_back('{data: d, push_e: e, pop_e: p});
      sb.push_back('{data: d, start: p + 1});
    end
  endtask

  task automatic drive(input logic en, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    bus.wr_en   = en;
    bus.wr_data = d;
    if (en && reset) model_push(d);
  endtask

  task automatic check_reset_state();
    chk("rst_tx",       bus.tx,       1);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_empty",    bus.empty,    1);
    chk("rst_full",     bus.full,     0);
    chk("rst_count",    bus.count,    0);
    chk("rst_overflow", bus.overflow, 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bus.wr_en  = 1'b0;
    hist.delete();
    sb.delete();
    last_pop   = -1000000;
    ovf_e      = 1 << 30;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_state();
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    int budget;
    budget = (sb.size() + 2) * (FB + 2) + 50;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout_pending", sb.size(), 0);
      sb.delete();
    end
    repeat (FB) @(posedge clk);
  endtask

  // Status monitor: occupancy, flags and busy against the model every cycle.
  initial begin : status_mon
    int k;
    int n;
    logic b;
    forever begin
      @(negedge clk);
      if (reset) begin
        k = cyc;
        n = 0;
        b = 1'b0;
        while (hist.size() > 0 && hist[0].pop_e + FB + 2 < k) void'(hist.pop_front());
        foreach (hist[i]) begin
          if (hist[i].push_e <= k && hist[i].pop_e > k) n++;
          if (hist[i].pop_e <= k && k < hist[i].pop_e + FB) b = 1'b1;
        end
        chk("count",    bus.count,    n);
        chk("full",     bus.full,     (n == DEPTH));
        chk("empty",    bus.empty,    (n == 0));
        chk("overflow", bus.overflow, (ovf_e <= k));
        chk("busy",     bus.busy,     b);
      end
    end
  end

  // Serial decoder: samples each bit mid-cell and scores the frame against the queue.
  initial begin : serial_mon
    bit            act;
    int            start;
    int            off;
    logic [15:0]   bits;
    logic [DW-1:0] d;
    exp_t          e;
    act  = 1'b0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = 1'b0;
      end else if (!act) begin
        if (bus.tx === 1'b0) begin
          act   = 1'b1;
          start = cyc;
        end
      end else begin
        off = cyc - start;
        if (off % BD == BD / 2) begin
          bits[off / BD] = bus.tx;
          if (off / BD == FRAME_BITS - 1) begin
            act = 1'b0;
            if (sb.size() == 0) begin
              chk("unexpected_frame", 1, 0);
            end else begin
              e = sb.pop_front();
              for (int i = 0; i < DW; i++) d[i] = bits[1 + i];
              chk("start_bit",  bits[0], 0);
              chk("frame_data", d, e.data);
              chk("frame_time", start, e.start);
`ifdef UART_TX_PARITY_EN
              chk("parity_bit", bits[1 + DW], ^e.data);
`endif
              for (int s = 0; s < SB; s++) chk("stop_bit", bits[1 + DW + PAR + s], 1);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;

    do_reset(3);

    drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    drain();

    drive(1'b1, 8'hA3);
    drive(1'b1, 8'h0F);
    drive(1'b1, 8'hFF);
    drive(1'b0, 8'h00);
    drain();

    // Keep the FSM busy with one frame, then overfill the buffer by one.
    drive(1'b1, 8'h11);
    repeat (3) drive(1'b0, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 8'($urandom));
    drive(1'b0, 8'h00);
    drain();

    drive(1'b1, 8'h07);
    drive(1'b0, 8'h00);
    drain();
    drive(1'b1, 8'h03);
    drive(1'b0, 8'h00);
    drain();

    // Abort mid-DATA, then one clean frame.
    drive(1'b1, 8'h81);
    repeat (10) drive(1'b0, 8'h00);
    do_reset(1);
    drive(1'b1, 8'h42);
    drive(1'b0, 8'h00);
    drain();

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        drive(1'b1, 8'($urandom));
        repeat ($urandom_range(0, 3)) drive(1'b0, 8'h00);
      end
      if (r == 5) begin
        for (int i = 0; i < DEPTH + 3; i++) drive(1'b1, 8'($urandom));
      end
      drive(1'b0, 8'h00);
      if (r == 8) begin
        repeat ($urandom_range(5, 30)) drive(1'b0, 8'h00);
        do_reset(1);
      end
      repeat ($urandom_range(0, 60)) drive(1'b0, 8'h00);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
